timebase_start_sequencer: RTL
=============================

Name: timebase_start_sequencer

Overview:
- Sits directly upstream of the per-chain timebase shifter/counter stages in the PWM generator.
- Turns one global start/stop command into per-chain timebase enable signals. Each chain's release is delayed by its own programmed phase-shift count.
- Self-contained: holds a shadow register and a down-counter per chain, under one global FSM.
- Ensures all chains start phase-aligned from a single start event.

Parameters:
- COUNTER_WIDTH, 16, width of each chain's phase-shift value and delay counter.
- N_CHAINS, 2, number of independently delayed timebase chains (>=1).

Ports:
- clockIn  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start request, level; rising edge detected internally.
- stop  in  1  stop request, level; takes priority over start.
- shift  in  N_CHAINS*COUNTER_WIDTH  per-chain delay in clock cycles. Chain i occupies bits [i*COUNTER_WIDTH +: COUNTER_WIDTH].
- timebase_enable  out  N_CHAINS  per-chain enable for the downstream timebase; sticky while running.
- busy  out  1  high in any state other than IDLE.
- aligned  out  1  one-cycle pulse when every chain has been enabled.

Behaviour:
- Reset (reset low, async):
  - state=IDLE.
  - timebase_enable=0, busy=0, aligned=0.
  - Shadow registers, counters and start_d (previous-start register) all 0.
- Edge detect: start_d is registered every cycle. start_rise = start & ~start_d. start_d resets to 0, so start held high through reset release counts as a rise on the first active edge.
- FSM states: IDLE, ARM, DELAY, RUN.
- IDLE:
  - On an edge with start_rise=1 and stop=0: shadow[i] <= shift[i] for all i; state <= ARM.
  - Otherwise remain in IDLE.
- ARM (exactly 1 cycle): cnt[i] <= shadow[i]; state <= DELAY.
- DELAY, per chain, each edge:
  - If cnt[i]==0: timebase_enable[i] <= 1.
  - Else: cnt[i] <= cnt[i]-1.
  - Enabled chains hold enable=1; their counter stays at 0.
  - When all timebase_enable bits are 1 (registered value): state <= RUN and aligned pulses high for 1 cycle on that same edge.
- RUN: enables held at 1; remain until stop.
- Latency: start_rise sampled at edge k gives timebase_enable[i] rising at edge k+2+shift[i]. With shift=0 this is edge k+2.
- aligned rises at edge k+3+max(shift).
- Arithmetic:
  - Decrement only when cnt is nonzero, so there is no wrap-around.
  - shift = all-ones is legal: delay of 2^COUNTER_WIDTH+1 cycles.
- Stop:
  - In ARM, DELAY or RUN, stop=1 at an edge gives: all timebase_enable <= 0, counters <= 0, aligned <= 0, state <= IDLE.
  - Stop in IDLE has no effect.
- Start while busy:
  - start_rise in ARM, DELAY or RUN is ignored.
  - Shift changes after capture do not affect the current sequence.
- Simultaneous start_rise and stop in IDLE: stop wins; remain in IDLE.
- Restart after stop: needs a fresh rising edge of start. A start held high across a stop does not restart.
- Async reset mid-sequence: all outputs drop immediately, without waiting for a clock edge. After reset release, operation resumes from IDLE.

Test Plan:
- Reset then idle: hold reset low, start=0 → timebase_enable=2'b00, busy=0, aligned=0; outputs stay 0 for 20 cycles after release.
- Basic stagger: N_CHAINS=2, shift={16'd5,16'd0}, start rise sampled at edge k → enable[0] high at k+2, enable[1] high at k+7, aligned single pulse at k+8, busy high from k.
- Mid-delay stop: shift={16'd100,16'd3}, stop asserted at k+10 → enable[0] (already high) and enable[1] low after edge k+10, busy low, aligned never pulses; a new start edge with the same shifts replays identical timing.
- Ignored restart / shadowing: after start, change shift to {16'd1,16'd1} and toggle start during DELAY → original delays apply, no second sequence, enables stay high in RUN.
- Priority corner: start rising with stop=1 in the same cycle in IDLE → no state change. Next, start held high across a stop during RUN → no restart until start falls and rises again.
- Async reset mid-RUN: assert reset low between clock edges → enables and busy drop within the same cycle (before next edge); after release with start held high → new sequence begins (rise seen because start_d reset to 0).

Source files
------------

// File: rtl/timebase_start_sequencer.sv
// Timebase start sequencer.
// Turns one global start/stop command into per-chain timebase enables.
// Each chain is released after its own captured phase-shift delay, so every
// chain starts phase-aligned to a single start event. One global FSM drives
// a shadow register and a down-counter per chain.
module timebase_start_sequencer #(
    parameter int COUNTER_WIDTH = 16,
    parameter int N_CHAINS      = 2
) (
    input  logic                              clockIn,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              stop,
    input  logic [N_CHAINS*COUNTER_WIDTH-1:0] shift,
    output logic [N_CHAINS-1:0]               timebase_enable,
    output logic                              busy,
    output logic                              aligned
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        DELAY = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    state_t              state_reg;
    logic                start_d_reg;
    logic                aligned_reg;
    logic                start_rise;
    logic                all_enabled;
    logic [N_CHAINS-1:0] chain_enable;

    // A rise is seen whenever start is high and was low at the previous edge;
    // start_d resets to 0, so a start held through reset release counts.
    assign start_rise  = start & ~start_d_reg;
    // Uses the registered enables, so RUN follows one edge after the last release.
    assign all_enabled = &chain_enable;

    // Previous-start register for rising-edge detection, sampled every cycle.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            start_d_reg <= 1'b0;
        end else begin
            start_d_reg <= start;
        end
    end

    // Global sequencing FSM; aligned is a registered single-cycle pulse.
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            aligned_reg <= 1'b0;
        end else begin
            aligned_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Stop wins over a simultaneous start rise.
                    if (start_rise && !stop) begin
                        state_reg <= ARM;
                    end
                end
                ARM: begin
                    state_reg <= stop ? IDLE : DELAY;
                end
                DELAY: begin
                    if (stop) begin
                        state_reg <= IDLE;
                    end else if (all_enabled) begin
                        state_reg   <= RUN;
                        aligned_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < N_CHAINS; gi++) begin : g_chain
            logic [COUNTER_WIDTH-1:0] shadow_reg;
            logic [COUNTER_WIDTH-1:0] cnt_reg;
            logic                     enable_reg;

            // Per-chain capture, countdown and sticky release of the timebase enable.
            always_ff @(posedge clockIn or negedge reset) begin
                if (!reset) begin
                    shadow_reg <= '0;
                    cnt_reg    <= '0;
                    enable_reg <= 1'b0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            // Shift is captured only on an accepted start, so later
                            // changes cannot disturb a sequence in flight.
                            if (start_rise && !stop) begin
                                shadow_reg <= shift[gi*COUNTER_WIDTH +: COUNTER_WIDTH];
                            end
                        end
                        ARM: begin
                            if (stop) begin
                                cnt_reg    <= '0;
                                enable_reg <= 1'b0;
                            end else begin
                                cnt_reg <= shadow_reg;
                            end
                        end
                        DELAY: begin
                            if (stop) begin
                                cnt_reg    <= '0;
                                enable_reg <= 1'b0;
                            end else if (cnt_reg == '0) begin
                                // Counter parks at zero once released; no wrap.
                                enable_reg <= 1'b1;
                            end else begin
                                cnt_reg <= cnt_reg - CNT_ONE;
                            end
                        end
                        RUN: begin
                            if (stop) begin
                                cnt_reg    <= '0;
                                enable_reg <= 1'b0;
                            end
                        end
                        default: begin
                            cnt_reg    <= '0;
                            enable_reg <= 1'b0;
                        end
                    endcase
                end
            end

            assign chain_enable[gi] = enable_reg;
        end
    endgenerate

    assign timebase_enable = chain_enable;
    assign busy            = (state_reg != IDLE);
    assign aligned         = aligned_reg;

endmodule
